// File: rtl/imem_rom.sv
// 64 x 32 instruction ROM for the single-cycle LEGv8 core, with a sticky past-end fetch flag.
// Define IMEM_REG_OUT_EN to register q (1-cycle read latency); the default build reads combinationally.
module imem_rom #(
    parameter int N        = 32,
    parameter int AW       = 6,
    parameter int PROG_LEN = 50
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] addr,
    output logic [N-1:0]  q,
    output logic          past_end
);

    localparam logic [AW:0] LIMIT = (AW+1)'(PROG_LEN);

    logic          out_of_range;
    logic [N-1:0]  rom_data;

    // An X address compares false here, so it can never set past_end.
    assign out_of_range = ({1'b0, addr} >= LIMIT);

    always_comb begin
        rom_data = '0;
        case (addr)
            6'd0:  rom_data = 32'hf8000001;
            6'd1:  rom_data = 32'hf8008002;
            6'd2:  rom_data = 32'hf8000203;
            6'd3:  rom_data = 32'h8b050083;
            6'd4:  rom_data = 32'hf8018003;
            6'd5:  rom_data = 32'hcb050083;
            6'd6:  rom_data = 32'hf8020003;
            6'd7:  rom_data = 32'hcb0a03e4;
            6'd8:  rom_data = 32'hf8028004;
            6'd9:  rom_data = 32'h8b040064;
            6'd10: rom_data = 32'hf8030004;
            6'd11: rom_data = 32'hcb030025;
            6'd12: rom_data = 32'hf8038005;
            6'd13: rom_data = 32'h8a1f0145;
            6'd14: rom_data = 32'hf8040005;
            6'd15: rom_data = 32'h8a030145;
            6'd16: rom_data = 32'hf8048005;
            6'd17: rom_data = 32'h8a140294;
            6'd18: rom_data = 32'hf8050014;
            6'd19: rom_data = 32'haa1f0166;
            6'd20: rom_data = 32'hf8058006;
            6'd21: rom_data = 32'haa030166;
            6'd22: rom_data = 32'hf8060006;
            6'd23: rom_data = 32'hf840000c;
            6'd24: rom_data = 32'h8b1f0187;
            6'd25: rom_data = 32'hf8068007;
            6'd26: rom_data = 32'hf807000c;
            6'd27: rom_data = 32'h8b0e01bf;
            6'd28: rom_data = 32'hf807801f;
            6'd29: rom_data = 32'hb4000040;
            6'd30: rom_data = 32'hf8080015;
            6'd31: rom_data = 32'hf8088015;
            6'd32: rom_data = 32'h8b0103e2;
            6'd33: rom_data = 32'hcb010042;
            6'd34: rom_data = 32'h8b0103f8;
            6'd35: rom_data = 32'hf8090018;
            6'd36: rom_data = 32'h8b080000;
            6'd37: rom_data = 32'hb4ffff82;
            6'd38: rom_data = 32'hf809001e;
            6'd39: rom_data = 32'h8b1e03de;
            6'd40: rom_data = 32'hcb1503f5;
            6'd41: rom_data = 32'h8b1403de;
            6'd42: rom_data = 32'hf85f83d9;
            6'd43: rom_data = 32'h8b1e03de;
            6'd44: rom_data = 32'h8b1003de;
            6'd45: rom_data = 32'hf81f83d9;
            6'd46: rom_data = 32'hb400001f;
            default: rom_data = '0;
        endcase
        // A shorter program length blanks the tail of the table as well.
        if (out_of_range)
            rom_data = '0;
    end

`ifdef IMEM_REG_OUT_EN
    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else
            q <= rom_data;
    end
`else
    assign q = rom_data;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            past_end <= 1'b0;
        else if (out_of_range)
            past_end <= 1'b1;
    end

endmodule

// File: tb/tb_imem_rom.sv
// Self-checking bench for imem_rom: ROM sweep through a scoreboard queue plus past_end sequencing.
module tb_imem_rom;

    logic        clk;
    logic        reset;
    logic [5:0]  addr;
    logic [31:0] q;
    logic        past_end;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];

    logic [31:0] prog [0:49] = '{
        32'hf8000001, 32'hf8008002, 32'hf8000203, 32'h8b050083, 32'hf8018003,
        32'hcb050083, 32'hf8020003, 32'hcb0a03e4, 32'hf8028004, 32'h8b040064,
        32'hf8030004, 32'hcb030025, 32'hf8038005, 32'h8a1f0145, 32'hf8040005,
        32'h8a030145, 32'hf8048005, 32'h8a140294, 32'hf8050014, 32'haa1f0166,
        32'hf8058006, 32'haa030166, 32'hf8060006, 32'hf840000c, 32'h8b1f0187,
        32'hf8068007, 32'hf807000c, 32'h8b0e01bf, 32'hf807801f, 32'hb4000040,
        32'hf8080015, 32'hf8088015, 32'h8b0103e2, 32'hcb010042, 32'h8b0103f8,
        32'hf8090018, 32'h8b080000, 32'hb4ffff82, 32'hf809001e, 32'h8b1e03de,
        32'hcb1503f5, 32'h8b1403de, 32'hf85f83d9, 32'h8b1e03de, 32'h8b1003de,
        32'hf81f83d9, 32'hb400001f, 32'h00000000, 32'h00000000, 32'h00000000
    };

    imem_rom #(.N(32), .AW(6), .PROG_LEN(50)) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .q        (q),
        .past_end (past_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input int a);
        return (a < 50) ? prog[a] : 32'h0;
    endfunction

    task automatic pop_chk(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty, got %h", tag, q);
        end else begin
            e = exp_q.pop_front();
            chk(tag, q, e);
        end
    endtask

    // Drive addr just after a rising edge, then compare once the read has resolved.
    task automatic fetch(input int a, input logic [31:0] expected, input string tag);
        @(posedge clk);
        #1;
        addr = 6'(a);
        exp_q.push_back(expected);
`ifdef IMEM_REG_OUT_EN
        @(posedge clk);
        #1;
`else
        #5;
`endif
        pop_chk(tag);
    endtask

    initial begin
        reset = 1'b1;
        addr  = 6'd0;
        @(posedge clk);
        #1;
        chk("reset_past_end", {31'b0, past_end}, 32'h0);
`ifdef IMEM_REG_OUT_EN
        chk("reset_q", q, 32'h0);
`endif
        reset = 1'b0;

`ifdef IMEM_REG_OUT_EN
        addr = 6'd3;
        #3;
        chk("regout_before_edge", q, 32'h0);
        @(posedge clk);
        #1;
        chk("regout_after_edge", q, 32'h8b050083);
`endif

        for (int i = 0; i < 50; i++)
            fetch(i, model(i), $sformatf("sweep_%0d", i));

        fetch(0,  32'hf8000001, "spot_0");
        fetch(29, 32'hb4000040, "spot_29");
        fetch(37, 32'hb4ffff82, "spot_37");
        fetch(46, 32'hb400001f, "spot_46");
        fetch(47, 32'h00000000, "spot_47");
        fetch(49, 32'h00000000, "spot_49");
        #3;
        chk("in_range_no_flag", {31'b0, past_end}, 32'h0);

        // One edge at addr=50 arms the flag.
        @(posedge clk);
        #1;
        addr = 6'd50;
        @(posedge clk);
        #1;
        addr = 6'd0;
        chk("flag_at_50", {31'b0, past_end}, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        chk("flag_sticky", {31'b0, past_end}, 32'h1);

        for (int i = 50; i < 64; i++)
            fetch(i, 32'h0, $sformatf("tail_%0d", i));

        // Reset wins over an out-of-range fetch on the same edge.
        @(posedge clk);
        #1;
        addr  = 6'd55;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_priority", {31'b0, past_end}, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rearm_after_reset", {31'b0, past_end}, 32'h1);

`ifndef IMEM_REG_OUT_EN
        addr = 6'd11;
        for (int i = 0; i < 8; i++) begin
            reset = (i % 3 == 0);
            exp_q.push_back(32'hcb030025);
            @(negedge clk);
            #1;
            pop_chk($sformatf("hold11_neg_%0d", i));
            exp_q.push_back(32'hcb030025);
            @(posedge clk);
            #1;
            pop_chk($sformatf("hold11_pos_%0d", i));
        end
        reset = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
